fetch_q: RTL and testbench
==========================

# fetch_q

Parametrised successor to the single-register fetch stage. Generates sequential RV32I instruction addresses from a programmable reset vector and issues them to an instruction memory with variable, in-order response latency. Buffers up to DEPTH instructions with their PCs and delivers them to decode over a valid/ready handshake. Execute-stage redirects (base + offset) flush the queue and discard stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4: queue entries and maximum outstanding requests; power of two, >= 2.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pc_ex_valid  in  1  redirect request from execute.
- pc_ex_base  in  32  redirect base.
- pc_ex_off  in  32  redirect offset; target = (base + off) mod 2^32, bits [1:0] forced to 0.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  30  word address, fetch_pc[31:2].
- mem_resp_valid  in  1  response valid; responses return in request order; no back-pressure.
- mem_data  in  32  response instruction word.
- de_valid  out  1  head entry holds an instruction.
- de_ready  in  1  decode accepts; low = stall.
- insn  out  32  head instruction.
- pc_de  out  32  PC of head instruction.

## Operation
- State: fetch_pc (32), entry arrays pc[DEPTH], insn[DEPTH], pointers head/fill/tail (clog2(DEPTH)+1 bits, wrap-bit compare), out_cnt and drop_cnt (0..DEPTH).
- Issue: mem_req_valid = (tail - head) < DEPTH and out_cnt < DEPTH. On req fire: pc[tail] <= fetch_pc, tail++, fetch_pc += 4 (wraps at 2^32), out_cnt++.
- Response: out_cnt--. If drop_cnt > 0: drop_cnt--, data discarded. Else insn[fill] <= mem_data, fill++.
- Deliver: de_valid = (fill != head); insn/pc_de driven from entry[head]. On de_valid & de_ready: head++.
- Redirect (pc_ex_valid): highest priority. fetch_pc <= target; head, fill, tail <= tail value (queue emptied); drop_cnt <= out_cnt + req_fire - resp_valid, i.e. every request not yet answered, including one firing this cycle, is stale. A delivery handshake in the redirect cycle still completes (execute squashes it).
- Redirect with no outstanding requests: drop_cnt = 0; next request is target.
- Response arriving with drop_cnt = 0 and no allocated unfilled entry is a protocol error; assertion only.
- out_cnt never exceeds DEPTH; drop_cnt never exceeds out_cnt.

## Timing
- Reset values: fetch_pc = RESET_PC, pointers 0, out_cnt = drop_cnt = 0, mem_req_valid = 0 during reset, de_valid = 0, insn = 0, pc_de = 0 when queue empty.
- mem_req_valid may assert in the first cycle after rst falls, with mem_addr = RESET_PC[31:2].
- mem_req_valid/mem_addr depend on registered state only; once asserted they hold until fire or redirect (redirect may retarget a pending, unaccepted request).
- Latency: response in cycle N -> de_valid in cycle N+1. Zero-wait memory sustains 1 instruction/cycle with de_ready high.
- Redirect in cycle N -> first request to target in cycle N+1.
- Full queue: mem_req_valid low until a dequeue; dequeue and issue in the same cycle both take effect.
- Async rst mid-operation: all state returns to reset values immediately; in-flight memory responses after reset are the memory's responsibility (memory reset together).

## Structure
- Package fetch_pkg: XLEN = 32, INSN_W = 32, ADDR_W = 30, the target alignment mask, pointer-width function.
- Sub-module fetch_q_ctr: counter with simultaneous inc/dec and load, used for out_cnt and drop_cnt.
- Entry storage is flops (DEPTH small); no RAM macro.

## Test plan
- Reset, RESET_PC = 32'h0000_0100, zero-wait memory, de_ready = 1 -> pc_de sequence 0x100, 0x104, 0x108, one per cycle, from the 2nd cycle after first fire.
- de_ready low for 10 cycles, DEPTH = 4 -> exactly 4 requests issued, mem_req_valid low thereafter; release -> 4 instructions in order, no loss.
- 3-cycle memory latency, 2 outstanding, redirect base 0x2000 off 0x11 -> both stale responses discarded, next pc_de = 0x2010.
- Redirect in same cycle as a response and a request fire -> drop_cnt = out_cnt, stale data never reaches decode.
- fetch_pc = 0xFFFF_FFFC -> next request address 0, pc_de = 0x0000_0000.
- rst asserted while queue holds 3 entries -> de_valid drops immediately; refetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, alignment mask and pointer sizing for the fetch queue.
package fetch_pkg;
  localparam int XLEN   = 32;
  localparam int INSN_W = 32;
  localparam int ADDR_W = 30;

  // Redirect targets are word aligned: low two bits cleared.
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } mem_req_t;
endpackage

// File: rtl/fetch_q_ctr.sv
// Saturation-free up/down counter with synchronous load; load wins.
module fetch_q_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);
  // Count register: load, else net +1/-1, simultaneous inc/dec cancels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (inc && !dec)  cnt <= cnt + 1'b1;
    else if (dec && !inc)  cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/fetch_q.sv
// Sequential instruction fetch with a DEPTH-entry PC/instruction queue,
// in-order variable-latency memory, and redirect flush with stale-drop.
module fetch_q
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_ex_valid,
  input  logic [XLEN-1:0]   pc_ex_base,
  input  logic [XLEN-1:0]   pc_ex_off,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_resp_valid,
  input  logic [INSN_W-1:0] mem_data,
  output logic              de_valid,
  input  logic              de_ready,
  output logic [INSN_W-1:0] insn,
  output logic [XLEN-1:0]   pc_de
);
  localparam int             PW      = ptr_w(DEPTH);
  localparam int             IW      = PW - 1;
  localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);

  logic [XLEN-1:0]                fetch_pc;
  logic [DEPTH-1:0][XLEN-1:0]     pc_q;
  logic [DEPTH-1:0][INSN_W-1:0]   insn_q;
  // head: next to deliver, fill: next to receive data, tail: next to allocate
  logic [PW-1:0] head, fill, tail;
  logic [PW-1:0] out_cnt, drop_cnt, drop_ld, used;
  logic          req_fire, resp_fill, resp_drop, deq;
  logic [XLEN-1:0] target;
  mem_req_t      req;

  assign used   = tail - head;
  assign target = (pc_ex_base + pc_ex_off) & ALIGN_MASK;

  // Request is a function of registered state only; held off while in reset.
  assign req.valid     = !rst && (used < DEPTH_P) && (out_cnt < DEPTH_P);
  assign req.addr      = fetch_pc[XLEN-1:2];
  assign mem_req_valid = req.valid;
  assign mem_addr      = req.addr;
  assign req_fire      = req.valid && mem_req_ready;

  assign resp_drop = mem_resp_valid && (drop_cnt != '0);
  assign resp_fill = mem_resp_valid && (drop_cnt == '0);

  assign de_valid = (fill != head);
  assign deq      = de_valid && de_ready;
  assign insn     = de_valid ? insn_q[head[IW-1:0]] : '0;
  assign pc_de    = de_valid ? pc_q[head[IW-1:0]]   : '0;

  // Everything still unanswered after this cycle becomes stale on redirect,
  // including a request accepted in the redirect cycle itself.
  assign drop_ld = out_cnt + PW'(req_fire) - PW'(mem_resp_valid);

  // Fetch address: redirect target overrides sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              fetch_pc <= RESET_PC;
    else if (pc_ex_valid) fetch_pc <= target;
    else if (req_fire)    fetch_pc <= fetch_pc + 32'd4;
  end

  // Queue pointers: redirect collapses the queue to empty at tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      fill <= '0;
      tail <= '0;
    end else if (pc_ex_valid) begin
      head <= tail;
      fill <= tail;
    end else begin
      if (req_fire)  tail <= tail + 1'b1;
      if (resp_fill) fill <= fill + 1'b1;
      if (deq)       head <= head + 1'b1;
    end
  end

  // Entry storage: PC captured at issue, instruction at response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      insn_q <= '0;
    end else begin
      if (req_fire)  pc_q[tail[IW-1:0]]   <= fetch_pc;
      if (resp_fill) insn_q[fill[IW-1:0]] <= mem_data;
    end
  end

  fetch_q_ctr #(.W(PW)) u_out_ctr (
    .clk(clk), .rst(rst), .inc(req_fire), .dec(mem_resp_valid),
    .load(1'b0), .load_val('0), .cnt(out_cnt)
  );

  fetch_q_ctr #(.W(PW)) u_drop_ctr (
    .clk(clk), .rst(rst), .inc(1'b0), .dec(resp_drop),
    .load(pc_ex_valid), .load_val(drop_ld), .cnt(drop_cnt)
  );

  a_resp_has_slot: assert property (@(posedge clk) disable iff (rst)
    mem_resp_valid |-> (drop_cnt != '0 || fill != tail));
  a_out_bound: assert property (@(posedge clk) disable iff (rst)
    out_cnt <= DEPTH_P);
  a_drop_bound: assert property (@(posedge clk) disable iff (rst)
    drop_cnt <= out_cnt);
endmodule

// File: tb/tb_fetch_q.sv
// Randomised and directed scoreboard bench for fetch_q.
module tb_fetch_q;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_ex_valid = 1'b0;
  logic [31:0] pc_ex_base = '0, pc_ex_off = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [29:0] mem_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        de_valid, de_ready = 1'b0;
  logic [31:0] insn, pc_de;

  always #5 clk = ~clk;

  fetch_q #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pc_ex_valid(pc_ex_valid), .pc_ex_base(pc_ex_base), .pc_ex_off(pc_ex_off),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_data(mem_data),
    .de_valid(de_valid), .de_ready(de_ready), .insn(insn), .pc_de(pc_de)
  );

  typedef struct { logic [31:0] pc; logic [31:0] insn; } exp_t;
  typedef struct { logic [29:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; int gen; } iss_t;

  exp_t  exp_q[$];   // expected deliveries, in order
  mreq_t mq[$];      // memory model: accepted requests awaiting response
  iss_t  iss[$];     // reference: issued, unanswered fetches with epoch

  int checks = 0, errors = 0;
  int cyc = 0, gen = 0, rst_cyc = 0, redir_cyc = 0, cov = 0;
  int lat_lo = 1, lat_hi = 1, rdy_pct = 100, de_pct = 100, redir_pct = 0, fire_budget = -1;
  int fires, dels, first_fire, first_del;
  logic [31:0] exp_pc = RPC;
  logic        force_redir = 1'b0;
  logic [31:0] f_base, f_off;
  logic [31:0] del_pc[$], fire_addr[$];
  exp_t        mon_e;

  function automatic logic [31:0] mem_fn(input logic [29:0] a);
    return ({a, 2'b00} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic clear_rec();
    fires = 0; dels = 0; first_fire = -1; first_del = -1;
    del_pc.delete(); fire_addr.delete();
  endtask

  // Monitor: every cycle, presence of a head entry and the delivered pair.
  always @(negedge clk) begin
    if (!rst) begin
      chk("de_valid", {31'b0, de_valid}, {31'b0, exp_q.size() != 0});
      if (de_valid && de_ready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("pc_de", pc_de, mon_e.pc);
        chk("insn", insn, mon_e.insn);
      end
    end
  end

  // One clock: drive inputs after the edge, evaluate the reference model
  // after the monitor has sampled on the falling edge.
  task automatic cycle_body();
    logic fire, resp, del, redir;
    mreq_t m;
    iss_t  it;
    exp_t  e;
    int    live;
    mem_req_ready = (fire_budget < 0) ? ($urandom_range(99) < rdy_pct) : (fire_budget > 0);
    de_ready      = $urandom_range(99) < de_pct;
    mem_resp_valid = (mq.size() != 0) && (mq[0].due <= cyc);
    mem_data       = mem_resp_valid ? mem_fn(mq[0].addr) : $urandom();
    if (force_redir) begin
      pc_ex_valid = 1'b1; pc_ex_base = f_base; pc_ex_off = f_off; force_redir = 1'b0;
    end else begin
      pc_ex_valid = $urandom_range(99) < redir_pct;
      pc_ex_base  = $urandom();
      pc_ex_off   = $urandom();
    end
    @(negedge clk); #1;
    fire  = mem_req_valid & mem_req_ready;
    resp  = mem_resp_valid;
    del   = de_valid & de_ready;
    redir = pc_ex_valid;
    // Issue allowed while live entries (waiting or filled) and total
    // outstanding requests are both below DEPTH.
    live = 0;
    foreach (iss[i]) if (iss[i].gen == gen) live++;
    chk("req_valid", {31'b0, mem_req_valid},
        {31'b0, ((live + exp_q.size() + (del ? 1 : 0)) < DEPTH) && (iss.size() < DEPTH)});
    if (fire) begin
      chk("mem_addr", {2'b0, mem_addr}, {2'b0, exp_pc[31:2]});
      m.addr = mem_addr; m.due = cyc + int'($urandom_range(lat_hi, lat_lo));
      mq.push_back(m);
      it.pc = exp_pc; it.gen = gen; iss.push_back(it);
      exp_pc = exp_pc + 32'd4;
      fires++; fire_addr.push_back({2'b0, mem_addr});
      if (first_fire < 0) first_fire = cyc;
      if (fire_budget > 0) fire_budget--;
    end
    if (resp && iss.size() != 0) begin
      m  = mq.pop_front();
      it = iss.pop_front();
      if (it.gen == gen) begin
        e.pc = it.pc; e.insn = mem_fn(it.pc[31:2]);
        exp_q.push_back(e);
      end
    end
    if (del) begin
      dels++; del_pc.push_back(pc_de);
      if (first_del < 0) first_del = cyc;
    end
    if (redir && fire && resp) cov++;
    if (redir) begin
      exp_pc = (pc_ex_base + pc_ex_off) & 32'hFFFF_FFFC;
      gen++;
      exp_q.delete();
      redir_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    cycle_body();
  endtask

  // Asserts reset mid-cycle, checks outputs at once, releases after an edge.
  task automatic do_reset();
    rst = 1'b1;
    pc_ex_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0; de_ready = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_de_valid", {31'b0, de_valid}, 32'd0);
    chk("rst_insn", insn, 32'd0);
    chk("rst_pc_de", pc_de, 32'd0);
    mq.delete(); iss.delete(); exp_q.delete();
    exp_pc = RPC; gen++;
    clear_rec();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rst_cyc = cyc;
    cycle_body();
  endtask

  initial begin
    #2;
    // Zero-wait memory, decode always ready: one instruction per cycle.
    do_reset();
    repeat (11) step();
    chk("first_fire_cyc", first_fire, rst_cyc);
    chk("fill_latency", first_del - first_fire, 32'd2);
    chk("stream_dels", dels, 32'd10);
    chk("seq0", qat(del_pc, 0), 32'h100);
    chk("seq1", qat(del_pc, 1), 32'h104);
    chk("seq2", qat(del_pc, 2), 32'h108);

    // Decode stalled: exactly DEPTH requests, then no loss on release.
    de_pct = 0;
    do_reset();
    repeat (9) step();
    chk("stall_fires", fires, DEPTH);
    chk("stall_req_low", {31'b0, mem_req_valid}, 32'd0);
    de_pct = 100;
    clear_rec();
    repeat (10) step();
    chk("rel0", qat(del_pc, 0), 32'h100);
    chk("rel1", qat(del_pc, 1), 32'h104);
    chk("rel2", qat(del_pc, 2), 32'h108);
    chk("rel3", qat(del_pc, 3), 32'h10C);

    // 3-cycle memory, two outstanding, then redirect to 0x2000 + 0x11.
    lat_lo = 3; lat_hi = 3; fire_budget = 2;
    do_reset();
    repeat (20) if (fires < 2) step();
    chk("two_out", fires, 32'd2);
    f_base = 32'h2000; f_off = 32'h11; force_redir = 1'b1;
    step();
    fire_budget = -1; rdy_pct = 100;
    clear_rec();
    repeat (12) step();
    chk("redir_addr", qat(fire_addr, 0), 32'h804);
    chk("redir_req_cyc", first_fire, redir_cyc + 1);
    chk("redir_pc_de", qat(del_pc, 0), 32'h2010);

    // Address wrap past the top of memory.
    lat_lo = 1; lat_hi = 1;
    f_base = 32'hFFFF_FFF0; f_off = 32'hC; force_redir = 1'b1;
    step();
    clear_rec();
    repeat (12) step();
    chk("wrap_pc_top", qat(del_pc, 0), 32'hFFFF_FFFC);
    chk("wrap_pc_zero", qat(del_pc, 1), 32'h0);
    chk("wrap_addr", qat(fire_addr, 1), 32'h0);

    // Reset with three instructions queued.
    de_pct = 0; fire_budget = 3;
    do_reset();
    repeat (6) step();
    chk("three_held", {31'b0, de_valid}, 32'd1);
    fire_budget = -1; de_pct = 100;
    do_reset();
    repeat (4) step();
    chk("refetch_addr", qat(fire_addr, 0), RPC >> 2);
    chk("refetch_cyc", first_fire, rst_cyc);

    // Random traffic: variable latency, back-pressure and redirects.
    lat_lo = 1; lat_hi = 4; rdy_pct = 70; de_pct = 60; redir_pct = 4;
    do_reset();
    repeat (3000) step();
    lat_lo = 1; lat_hi = 1; rdy_pct = 100; de_pct = 90; redir_pct = 10;
    repeat (2000) step();
    chk("redir_resp_fire_seen", {31'b0, cov > 0}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
